div_radix2: RTL and testbench



---
 rtl/div_radix2.sv | 124 ++++++++++++
 tb/tb_div_radix2.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// Iterative restoring divider for the EX-stage ALU.
// One quotient bit per cycle; signs are fixed up on the final iteration.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div,
  input  logic             div_signed,
  input  logic             div_cancel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_complete,
  output logic             div_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             qneg;
  logic             rneg;

  logic             start;
  logic             last;
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] rem_nxt;

  assign start = (state == IDLE) && div && !div_cancel;
  assign last  = (state == CALC) && (cnt == LAST);

  always_comb begin
    x_abs = x;
    y_abs = y;
    if (div_signed && x[WIDTH-1]) x_abs = -x;
    if (div_signed && y[WIDTH-1]) y_abs = -y;
  end

  // A borrow out of t means the divisor did not fit: restore.
  always_comb begin
    sh = {rem, q[WIDTH-1]};
    t  = sh - {1'b0, dvs};
    if (!t[WIDTH]) begin
      rem_nxt = t[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = sh[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    div_complete = 1'b0;
    div_busy     = (state != IDLE);
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        state_nxt    = IDLE;
        div_complete = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (div_cancel) begin
      state_nxt    = IDLE;
      div_complete = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      q    <= '0;
      dvs  <= '0;
      rem  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      s    <= '0;
      r    <= '0;
    end else if (!div_cancel) begin
      if (start) begin
        cnt  <= '0;
        q    <= x_abs;
        dvs  <= y_abs;
        rem  <= '0;
        qneg <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
        rneg <= div_signed & x[WIDTH-1];
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        q   <= q_nxt;
        rem <= rem_nxt;
        if (last) begin
          s <= qneg ? -q_nxt : q_nxt;
          r <= rneg ? -rem_nxt : rem_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signs,
// divide-by-zero, overflow, back-to-back, cancel and reset.
module tb_div_radix2;

  logic        clk;
  logic        resetn;
  logic        div;
  logic        div_signed;
  logic        div_cancel;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] s;
  logic [31:0] r;
  logic        div_complete;
  logic        div_busy;

  int checks;
  int failures;

  div_radix2 #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div          (div),
    .div_signed   (div_signed),
    .div_cancel   (div_cancel),
    .x            (x),
    .y            (y),
    .s            (s),
    .r            (r),
    .div_complete (div_complete),
    .div_busy     (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until div_complete is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!div_complete && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic sg,
                     input logic [31:0] es,
                     input logic [31:0] er);
    int n;
    x = a;
    y = b;
    div_signed = sg;
    div = 1'b1;
    tick();
    div = 1'b0;
    x = 32'h1234_5678;
    chk({tag, "_busy"}, 32'(div_busy), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, n + 1, 32'd33);
    chk({tag, "_s"}, s, es);
    chk({tag, "_r"}, r, er);
    tick();
    chk({tag, "_pulse"}, 32'(div_complete), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    div        = 1'b0;
    div_signed = 1'b0;
    div_cancel = 1'b0;
    x          = '0;
    y          = '0;
    tick();
    chk("rst_s", s, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_cmp", 32'(div_complete), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
        32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
        32'hFFFF_FFFD, 32'd1);
    run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
        32'h8000_0000, 32'd0);
    run("u_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
        32'd0, 32'h8000_0000);
    run("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
    run("sm5_0", 32'hFFFF_FFFB, 32'd0, 1'b1,
        32'd1, 32'hFFFF_FFFB);

    // Back-to-back with div held high; x changes mid-CALC.
    x = 32'd20;
    y = 32'd3;
    div_signed = 1'b0;
    div = 1'b1;
    tick();
    x = 32'd999;
    y = 32'd1;
    wait_done(n);
    chk("b2b1_lat", n + 1, 32'd33);
    chk("b2b1_s", s, 32'd6);
    chk("b2b1_r", r, 32'd2);
    x = 32'd9;
    y = 32'd9;
    tick();
    chk("b2b_idle", 32'(div_busy), 32'd0);
    wait_done(n);
    chk("b2b2_lat", n + 34, 32'd67);
    chk("b2b2_s", s, 32'd1);
    chk("b2b2_r", r, 32'd0);
    div = 1'b0;
    tick();

    // Cancel wins over a start in IDLE.
    x = 32'd50;
    y = 32'd5;
    div = 1'b1;
    div_cancel = 1'b1;
    tick();
    div = 1'b0;
    div_cancel = 1'b0;
    chk("canc_start", 32'(div_busy), 32'd0);

    // Cancel in cycle 10 of an operation.
    div = 1'b1;
    tick();
    div = 1'b0;
    repeat (9) tick();
    div_cancel = 1'b1;
    #1;
    chk("canc_cmp", 32'(div_complete), 32'd0);
    tick();
    div_cancel = 1'b0;
    chk("canc_idle", 32'(div_busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (div_complete) seen = 1'b1;
      tick();
    end
    chk("canc_nopulse", 32'(seen), 32'd0);
    chk("canc_s", s, 32'd1);
    chk("canc_r", r, 32'd0);

    // Reset asserted in cycle 20.
    x = 32'd100;
    y = 32'd7;
    div = 1'b1;
    tick();
    div = 1'b0;
    repeat (19) tick();
    resetn = 1'b0;
    #1;
    chk("arst_s", s, 32'd0);
    chk("arst_r", r, 32'd0);
    chk("arst_busy", 32'(div_busy), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      if (div_complete) seen = 1'b1;
      tick();
    end
    chk("arst_nopulse", 32'(seen), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    run("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
